// File: rtl/mem_requester_pkg.sv
// mem_requester_pkg: shared widths, phase-count limits and FSM state encoding
package mem_requester_pkg;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int CYC_MIN = 1;
  localparam int CYC_MAX = 15;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RESP} state_t;
  function automatic logic [3:0] cyc_load(input int n);
    return n < CYC_MIN ? 4'd0 : n > CYC_MAX ? 4'(CYC_MAX - 1) : 4'(n - 1);
  endfunction
endpackage

// File: rtl/mem_requester_if.sv
// mem_requester_if: CPU request/response and memory strobe bus
interface mem_requester_if;
  import mem_requester_pkg::*;
  logic              reqValid;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic              reqReady;
  logic              respValid;
  logic              respReady;
  logic [DATA_W-1:0] respData;
  logic [ADDR_W-1:0] readMem;
  logic [ADDR_W-1:0] writeMem;
  logic [DATA_W-1:0] writeData;
  logic              trigRead;
  logic              trigWrite;
  logic [DATA_W-1:0] readData;
  modport slave (
    input  reqValid, reqWrite, reqAddr, reqData, respReady, readData,
    output reqReady, respValid, respData, readMem, writeMem, writeData, trigRead, trigWrite
  );
  modport master (
    output reqValid, reqWrite, reqAddr, reqData, respReady, readData,
    input  reqReady, respValid, respData, readMem, writeMem, writeData, trigRead, trigWrite
  );
endinterface

// File: rtl/mem_req_timer.sv
// mem_req_timer: 4-bit down-counter timing the SETUP and STROBE phases
module mem_req_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_expire
);
  logic [3:0] r_cnt;
  // load a phase length, then count down and park at zero
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
  assign o_expire = r_cnt == '0;
endmodule

// File: rtl/mem_requester.sv
// mem_requester: strobe-based memory access controller; MEM_REQUESTER_VERIFY_EN adds store read-back and verifyErr
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  mem_requester_if.slave bus
`ifdef MEM_REQUESTER_VERIFY_EN
  ,
  output logic verifyErr
`endif
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data, r_respData;
  logic              r_write, r_trigRead, r_trigWrite;
  logic              w_accept, w_verify, w_reverify, w_readDir, w_load, w_expire;
  logic [3:0]        w_loadVal;

  assign w_accept  = r_state == IDLE && bus.reqValid;
  assign w_readDir = !r_write || w_verify;

  mem_req_timer u_timer (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_load),
    .i_val   (w_loadVal),
    .o_expire(w_expire)
  );

`ifdef MEM_REQUESTER_VERIFY_EN
  logic r_verify;
  assign w_verify   = r_verify;
  assign w_reverify = r_write && !r_verify;
  // after a store's RELEASE, run one extra read pass and compare it with the stored word
  always_ff @(posedge clk)
    if (reset) begin
      r_verify  <= 1'b0;
      verifyErr <= 1'b0;
    end else if (w_accept) begin
      r_verify  <= 1'b0;
      verifyErr <= 1'b0;
    end else if (r_state == RELEASE) begin
      r_verify <= w_reverify;
      if (r_verify) verifyErr <= bus.readData != r_data;
    end
`else
  assign w_verify   = 1'b0;
  assign w_reverify = 1'b0;
`endif

  // next state and phase timer loads
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_loadVal = cyc_load(SETUP_CYCLES);
    case (r_state)
      IDLE:    if (bus.reqValid) begin
                 w_next = SETUP;
                 w_load = 1'b1;
               end
      SETUP:   if (w_expire) begin
                 w_next    = STROBE;
                 w_load    = 1'b1;
                 w_loadVal = cyc_load(STROBE_CYCLES);
               end
      STROBE:  if (w_expire) w_next = RELEASE;
      RELEASE: begin
                 w_next = w_reverify ? SETUP : RESP;
                 w_load = w_reverify;
               end
      RESP:    if (bus.respReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state, latched request, flop-driven strobes and response capture
  always_ff @(posedge clk)
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_respData  <= '0;
      r_trigRead  <= 1'b0;
      r_trigWrite <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_trigRead  <= w_next == STROBE && w_readDir;
      r_trigWrite <= w_next == STROBE && !w_readDir;
      if (w_accept) begin
        r_addr  <= bus.reqAddr;
        r_data  <= bus.reqData;
        r_write <= bus.reqWrite;
      end
      if (r_state == RELEASE && !w_reverify) r_respData <= r_write ? r_data : bus.readData;
    end

  assign bus.reqReady  = r_state == IDLE;
  assign bus.respValid = r_state == RESP;
  assign bus.respData  = r_respData;
  assign bus.readMem   = r_addr;
  assign bus.writeMem  = r_addr;
  assign bus.writeData = r_data;
  assign bus.trigRead  = r_trigRead;
  assign bus.trigWrite = r_trigWrite;
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed bench for default and 3/2-cycle requesters sharing one memory model
module tb_mem_requester;
`ifdef MEM_REQUESTER_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif
  logic        clk = 1'b0;
  logic        reset, valid, wr, sel, rready;
  logic [6:0]  addr;
  logic [31:0] data;
  logic [31:0] mem [128];
  logic [31:0] rd1 = '0, rd2 = '0;
  logic        p1r = 1'b0, p1w = 1'b0, p2r = 1'b0, p2w = 1'b0;
  logic        ve1, ve2;
  int          n_chk = 0, n_bad = 0, both_hi = 0;
  logic        o_rdy, o_rv, o_tr, o_tw;
  logic [31:0] o_rd;

  mem_requester_if b1();
  mem_requester_if b2();

  mem_requester dut (
    .clk  (clk),
    .reset(reset),
    .bus  (b1)
`ifdef MEM_REQUESTER_VERIFY_EN
    ,
    .verifyErr(ve1)
`endif
  );

  mem_requester #(.SETUP_CYCLES(3), .STROBE_CYCLES(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (b2)
`ifdef MEM_REQUESTER_VERIFY_EN
    ,
    .verifyErr(ve2)
`endif
  );

`ifndef MEM_REQUESTER_VERIFY_EN
  assign ve1 = 1'b0;
  assign ve2 = 1'b0;
`endif

  always #5 clk = ~clk;

  assign b1.reqValid  = valid && !sel;
  assign b2.reqValid  = valid && sel;
  assign b1.reqWrite  = wr;
  assign b2.reqWrite  = wr;
  assign b1.reqAddr   = addr;
  assign b2.reqAddr   = addr;
  assign b1.reqData   = data;
  assign b2.reqData   = data;
  assign b1.respReady = rready;
  assign b2.respReady = rready;
  assign b1.readData  = rd1;
  assign b2.readData  = rd2;
  assign o_rdy = sel ? b2.reqReady  : b1.reqReady;
  assign o_rv  = sel ? b2.respValid : b1.respValid;
  assign o_rd  = sel ? b2.respData  : b1.respData;
  assign o_tr  = sel ? b2.trigRead  : b1.trigRead;
  assign o_tw  = sel ? b2.trigWrite : b1.trigWrite;

  function automatic logic [31:0] flip(input logic [6:0] a);
    return (VX != 0 && a == 7'd9) ? 32'd1 : 32'd0;
  endfunction

  // memory model: acts on trigger rising edges; in verify builds addr 9 reads back with bit 0 flipped
  always @(negedge clk) begin
    if (b1.trigWrite && !p1w) mem[b1.writeMem] <= b1.writeData;
    if (b2.trigWrite && !p2w) mem[b2.writeMem] <= b2.writeData;
    if (b1.trigRead && !p1r) rd1 <= mem[b1.readMem] ^ flip(b1.readMem);
    if (b2.trigRead && !p2r) rd2 <= mem[b2.readMem] ^ flip(b2.readMem);
    p1r <= b1.trigRead;
    p1w <= b1.trigWrite;
    p2r <= b2.trigRead;
    p2w <= b2.trigWrite;
  end

  always @(negedge clk)
    if ((b1.trigRead && b1.trigWrite) || (b2.trigRead && b2.trigWrite)) both_hi++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic s, input logic w, input logic [6:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat, output int pre, output int tr, output int tw);
    int n;
    sel = s;
    n = 0;
    while (!o_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b1; wr = w; addr = a; data = d;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1; pre = 0; tr = 0; tw = 0;
    while (!o_rv && lat < 60) begin
      if (o_tr) tr++;
      if (o_tw) tw++;
      if (!o_tr && !o_tw && tr + tw == 0) pre++;
      @(posedge clk); #1;
      lat++;
    end
    check("resp_seen", 32'(o_rv), 1);
    rd = o_rd;
    if (rready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, pre, tr, tw, n, stab;
    reset = 1'b1; valid = 1'b0; wr = 1'b0; addr = '0; data = '0; rready = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rv", 32'(b1.respValid), 0);
    check("rst_tr", 32'(b1.trigRead), 0);
    check("rst_tw", 32'(b1.trigWrite), 0);
    check("rst_rdata", b1.respData, 0);
    check("rst_rmem", 32'(b1.readMem), 0);
    check("rst_wmem", 32'(b1.writeMem), 0);
    check("rst_wdata", b1.writeData, 0);
    check("rst_verr", 32'(ve1), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", 32'(b1.reqReady), 1);
    run_req(0, 1, 7'd5, 32'hDEADBEEF, rd, lat, pre, tr, tw);
    check("st5_ack", rd, 32'hDEADBEEF);
    check("st5_lat", lat, 4 + 3 * VX);
    check("st5_tw", tw, 1);
    check("st5_tr", tr, VX);
    run_req(0, 0, 7'd5, 32'h0, rd, lat, pre, tr, tw);
    check("ld5_data", rd, 32'hDEADBEEF);
    check("ld5_lat", lat, 4);
    check("ld5_tr", tr, 1);
    check("ld5_tw", tw, 0);
    run_req(0, 1, 7'd0, 32'h00000001, rd, lat, pre, tr, tw);
    run_req(0, 1, 7'd127, 32'hFFFFFFFF, rd, lat, pre, tr, tw);
    check("st127_ack", rd, 32'hFFFFFFFF);
    run_req(0, 0, 7'd0, 32'h0, rd, lat, pre, tr, tw);
    check("ld0_data", rd, 32'h00000001);
    run_req(0, 0, 7'd127, 32'h0, rd, lat, pre, tr, tw);
    check("ld127_data", rd, 32'hFFFFFFFF);
    check("ld127_lat", lat, 4);
    rready = 1'b0;
    run_req(0, 0, 7'd5, 32'h0, rd, lat, pre, tr, tw);
    check("hold_first", rd, 32'hDEADBEEF);
    valid = 1'b1; wr = 1'b0; addr = 7'd127;
    stab = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!o_rv || o_rd !== 32'hDEADBEEF || o_rdy) stab++;
    end
    check("hold_stable", stab, 0);
    rready = 1'b1;
    @(posedge clk); #1;
    check("hold_rv_drop", 32'(o_rv), 0);
    check("hold_rdy_idle", 32'(o_rdy), 1);
    @(posedge clk); #1;
    valid = 1'b0;
    check("hold_accepted", 32'(o_rdy), 0);
    n = 0;
    while (!o_rv && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_next_data", o_rd, 32'hFFFFFFFF);
    @(posedge clk); #1;
    valid = 1'b1; wr = 1'b1; addr = 7'd33; data = 32'hCAFE0001;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_strobe", 32'(o_tw), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstw_tw", 32'(o_tw), 0);
    check("rstw_tr", 32'(o_tr), 0);
    check("rstw_rv", 32'(o_rv), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstw_rdy", 32'(o_rdy), 1);
    stab = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (o_rv || o_tw || o_tr) stab++;
    end
    check("rstw_no_resp", stab, 0);
    check("rstw_kept", mem[33], 32'hCAFE0001);
    run_req(1, 1, 7'd77, 32'h12345678, rd, lat, pre, tr, tw);
    check("slow_st_pre", pre, 3);
    check("slow_st_tw", tw, 2);
    check("slow_st_tr", tr, 2 * VX);
    check("slow_st_lat", lat, 7 + 6 * VX);
    run_req(1, 0, 7'd77, 32'h0, rd, lat, pre, tr, tw);
    check("slow_ld_pre", pre, 3);
    check("slow_ld_tr", tr, 2);
    check("slow_ld_lat", lat, 7);
    check("slow_ld_data", rd, 32'h12345678);
`ifdef MEM_REQUESTER_VERIFY_EN
    run_req(0, 1, 7'd9, 32'h10, rd, lat, pre, tr, tw);
    check("ver9_err", 32'(ve1), 1);
    check("ver9_lat", lat, 7);
    run_req(0, 1, 7'd10, 32'h10, rd, lat, pre, tr, tw);
    check("ver10_err", 32'(ve1), 0);
    check("ver2_err", 32'(ve2), 0);
`endif
    check("trig_excl", both_hi, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
